// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory port arbiter.
// Macro ARB_RR_EN: when defined, ties alternate using a last-grant flop;
// otherwise DM always beats IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic   clk,
  input  logic   reset,
`endif
  input  logic   if_req,
  input  logic   dm_req,
  input  state_t state,
  output owner_t grant
);

`ifdef ARB_RR_EN
  // 1 when DM received the most recent grant; resets to "IF granted last"
  logic last_dm;

  // Pick an owner only in IDLE; a tie goes to the port not granted last
  always_comb begin
    grant = OWN_NONE;
    if (state == IDLE) begin
      if (if_req && dm_req) begin
        grant = last_dm ? OWN_IF : OWN_DM;
      end else if (dm_req) begin
        grant = OWN_DM;
      end else if (if_req) begin
        grant = OWN_IF;
      end
    end
  end

  // Remember which port won every time a grant is actually issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dm <= 1'b0;
    end else if (grant != OWN_NONE) begin
      last_dm <= (grant == OWN_DM);
    end
  end
`else
  // Pick an owner only in IDLE; DM wins because it serves the older instruction
  always_comb begin
    grant = OWN_NONE;
    if (state == IDLE) begin
      if (dm_req) begin
        grant = OWN_DM;
      end else if (if_req) begin
        grant = OWN_IF;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle word memory between the IF and DM ports of the core.
// Macro ARB_RR_EN (handled in mem_arb_pick) selects alternating tie priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(MEM_LAT - 1);

  state_t            state;
  owner_t            owner;
  owner_t            grant;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_cycle;

  mem_arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .if_req (if_req),
    .dm_req (dm_req),
    .state  (state),
    .grant  (grant)
  );

  // Access sequencer: latch the winner's request in IDLE, count down the latency in BUSY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant == OWN_DM) begin
            owner   <= OWN_DM;
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
            cnt     <= LOAD_CNT;
            state   <= BUSY;
          end else if (grant == OWN_IF) begin
            owner   <= OWN_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt     <= LOAD_CNT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            owner <= OWN_NONE;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Memory side and completion signals derive only from the latched access
  always_comb begin
    last_cycle = (state == BUSY) && (cnt == '0);
    mem_en     = (state == BUSY);
    mem_we     = last_cycle && we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    if_ready   = last_cycle && (owner == OWN_IF);
    dm_ready   = last_cycle && (owner == OWN_DM);
    if_rdata   = if_ready ? mem_rdata : '0;
    dm_rdata   = (dm_ready && !we_q) ? mem_rdata : '0;
    if_stall   = if_req && !if_ready;
    dm_stall   = dm_req && !dm_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=2) with a 256-word memory model.
// Honours ARB_RR_EN for the continuous-contention grant order.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cycle;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_ready, if_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_ready, dm_stall;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] mem     [0:255];
  logic [DATA_W-1:0] ref_mem [0:255];

  exp_t if_q[$];
  exp_t dm_q[$];
  exp_t e_if, e_dm;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write on the clock edge when strobed
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr[7:0]] <= mem_wdata;
  end

  // Scoreboard: every ready pulse must match the oldest expectation for that port
  always @(negedge clk) begin
    if (if_ready === 1'b1) begin
      tests_run++;
      if (if_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL if_unexpected_ready at cycle %0d got ready=1 required none", cyc);
      end else begin
        e_if = if_q.pop_front();
        if (if_rdata !== e_if.data || cyc != e_if.cycle) begin
          tests_failed++;
          $display("[TB] FAIL if_ready_data got %h at cycle %0d required %h at cycle %0d",
                   if_rdata, cyc, e_if.data, e_if.cycle);
        end
      end
    end
    if (dm_ready === 1'b1) begin
      tests_run++;
      if (dm_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL dm_unexpected_ready at cycle %0d got ready=1 required none", cyc);
      end else begin
        e_dm = dm_q.pop_front();
        if (dm_rdata !== e_dm.data || cyc != e_dm.cycle) begin
          tests_failed++;
          $display("[TB] FAIL dm_ready_data got %h at cycle %0d required %h at cycle %0d",
                   dm_rdata, cyc, e_dm.data, e_dm.cycle);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [DATA_W-1:0] d, input int c);
    exp_t r;
    r.data  = d;
    r.cycle = c;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    if_req = 1'b1;
    dm_req = 1'b0;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_controls got %b required 0000", {mem_en, mem_we, if_ready, dm_ready});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_buses got addr=%h wdata=%h if_rdata=%h dm_rdata=%h required all 0",
               mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    tests_run++;
    if (if_stall !== 1'b1 || dm_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stalls got if=%b dm=%b required if=1 dm=0", if_stall, dm_stall);
    end
    if_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_lone_fetch();
    int base;
    if_req  = 1'b1;
    if_addr = 30'h100000;
    base    = cyc;
    if_q.push_back(mk(ref_mem[0], base + 2));
    for (int k = 0; k < 4; k++) begin
      if (k == 3) if_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_en !== (k == 1 || k == 2)) begin
        tests_failed++;
        $display("[TB] FAIL fetch_mem_en cycle %0d got %b required %b", k, mem_en, (k == 1 || k == 2));
      end
      tests_run++;
      if (if_stall !== (k <= 1)) begin
        tests_failed++;
        $display("[TB] FAIL fetch_if_stall cycle %0d got %b required %b", k, if_stall, (k <= 1));
      end
      if (k == 2) begin
        tests_run++;
        if (mem_addr !== 30'h100000) begin
          tests_failed++;
          $display("[TB] FAIL fetch_mem_addr got %h required 100000", mem_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_store_load();
    int base;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 30'h4;
    dm_wdata = 32'hDEADBEEF;
    base     = cyc;
    ref_mem[4] = 32'hDEADBEEF;
    dm_q.push_back(mk(32'h0, base + 2));
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        dm_addr  = 30'h8;
        dm_wdata = 32'h0BADF00D;
        dm_we    = 1'b0;
      end
      if (k == 3) dm_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_we !== (k == 2)) begin
        tests_failed++;
        $display("[TB] FAIL store_mem_we cycle %0d got %b required %b", k, mem_we, (k == 2));
      end
      if (k == 2) begin
        tests_run++;
        if (mem_addr !== 30'h4 || mem_wdata !== 32'hDEADBEEF) begin
          tests_failed++;
          $display("[TB] FAIL store_bus got addr=%h data=%h required addr=4 data=deadbeef",
                   mem_addr, mem_wdata);
        end
      end
      next_cycle();
    end
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 30'h4;
    base    = cyc;
    dm_q.push_back(mk(ref_mem[4], base + 2));
    for (int k = 0; k < 4; k++) begin
      if (k == 3) dm_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_we !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL load_mem_we cycle %0d got %b required 0", k, mem_we);
      end
      next_cycle();
    end
  endtask

  task automatic test_simultaneous();
    int base;
    do_reset();
    if_req  = 1'b1;
    if_addr = 30'h10;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 30'h20;
    base    = cyc;
    dm_q.push_back(mk(ref_mem[8'h20], base + 2));
    if_q.push_back(mk(ref_mem[8'h10], base + 5));
    for (int k = 0; k < 7; k++) begin
      if (k == 3) dm_req = 1'b0;
      if (k == 6) if_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (if_stall !== (k <= 4) || dm_stall !== (k <= 1)) begin
        tests_failed++;
        $display("[TB] FAIL simul_stalls cycle %0d got if=%b dm=%b required if=%b dm=%b",
                 k, if_stall, dm_stall, (k <= 4), (k <= 1));
      end
      if (k == 4) begin
        tests_run++;
        if (mem_en !== 1'b1 || mem_addr !== 30'h10) begin
          tests_failed++;
          $display("[TB] FAIL simul_if_grant got en=%b addr=%h required en=1 addr=10", mem_en, mem_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_contention_order();
    int base;
    bit is_dm [4];
`ifdef ARB_RR_EN
    is_dm = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    is_dm = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    if_req  = 1'b1;
    if_addr = 30'h10;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 30'h20;
    base    = cyc;
    for (int j = 0; j < 4; j++) begin
      if (is_dm[j]) dm_q.push_back(mk(ref_mem[8'h20], base + 2 + 3 * j));
      else          if_q.push_back(mk(ref_mem[8'h10], base + 2 + 3 * j));
    end
    for (int k = 0; k < 13; k++) begin
      if (k == 12) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      @(negedge clk);
      if (k % 3 == 1 && k < 12) begin
        tests_run++;
        if (mem_addr !== (is_dm[k / 3] ? 30'h20 : 30'h10)) begin
          tests_failed++;
          $display("[TB] FAIL order_grant access %0d got addr=%h required %h",
                   k / 3, mem_addr, (is_dm[k / 3] ? 30'h20 : 30'h10));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_access();
    int base;
    do_reset();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 30'h30;
    dm_wdata = 32'h12345678;
    next_cycle();
    reset  = 1'b1;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || dm_ready !== 1'b0 || mem_addr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_abort got en=%b we=%b ready=%b addr=%h required 0 0 0 0",
               mem_en, mem_we, dm_ready, mem_addr);
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_idle cycle %0d got en=%b we=%b required 0 0", k, mem_en, mem_we);
      end
      next_cycle();
    end
    tests_run++;
    if (mem[8'h30] !== ref_mem[8'h30]) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_write got %h required %h", mem[8'h30], ref_mem[8'h30]);
    end
    if_req  = 1'b1;
    if_addr = 30'h40;
    base    = cyc;
    if_q.push_back(mk(ref_mem[8'h40], base + MEM_LAT));
    for (int k = 0; k < 4; k++) begin
      if (k == 3) if_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_en !== (k == 1 || k == 2)) begin
        tests_failed++;
        $display("[TB] FAIL midreset_next_en cycle %0d got %b required %b", k, mem_en, (k == 1 || k == 2));
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    if_req  = 1'b1;
    if_addr = 30'h40;
    base    = cyc;
    for (int j = 0; j < 3; j++) if_q.push_back(mk(ref_mem[8'h40 + j], base + 2 + 3 * j));
    for (int k = 0; k < 10; k++) begin
      if (k == 3) if_addr = 30'h41;
      if (k == 6) if_addr = 30'h42;
      if (k == 9) if_req = 1'b0;
      @(negedge clk);
      if (k >= 1) begin
        tests_run++;
        if (mem_addr !== 30'h40 + 30'((k - 1) / 3)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_mem_addr cycle %0d got %h required %h",
                   k, mem_addr, 30'h40 + 30'((k - 1) / 3));
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[0]     = 32'h8C080004;
    ref_mem[0] = 32'h8C080004;
    if_addr  = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    do_reset();
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_simultaneous();
    test_contention_order();
    test_reset_mid_access();
    test_back_to_back();
    next_cycle();
    next_cycle();
    tests_run++;
    if (if_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL if_missing_ready got %0d outstanding required 0", if_q.size());
    end
    tests_run++;
    if (dm_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL dm_missing_ready got %0d outstanding required 0", dm_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
